// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on both sides.
// One 2*WIDTH-bit adder is reused for exactly WIDTH iterations per product.
module mult_seq_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;
    logic                 w_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Iteration arithmetic: conditional add of the shifted multiplicand
    always_comb begin
        w_addend  = {(2*WIDTH){1'b0}};
        w_acc_sum = {(2*WIDTH){1'b0}};
        w_last    = 1'b0;
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {(2*WIDTH){1'b0}};
        end
        w_acc_sum = r_acc + w_addend;
        w_last    = (r_cnt <= CW'(1));
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift/add iterations, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= {(2*WIDTH){1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_cnt    <= CNT_INIT;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - CW'(1);
                    // Product only moves on the CALC->HOLD edge and is held afterwards
                    if (w_last) begin
                        r_product <= w_acc_sum;
                    end
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // Handshake outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_HOLD);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed vectors plus an exhaustive 6x6 sweep with
// random output stalls; a negedge monitor pops expected products on each output handshake.
module tb_mult_seq_ctrl;

    localparam int W = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [2*W-1:0] product;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc_edge;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rnd_ready = 1'b0;
    bit   prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on rising out_valid, product every HOLD cycle, pop on handshake
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_valid: got out_valid=1, expected no pending result");
            end else begin
                if (!prev_valid) check("latency", cyc - q[0].acc_edge, W);
                check("product", {20'd0, product}, {20'd0, q[0].prod});
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_valid = rst_n && out_valid;
    end

    // Random downstream stalls while the sweep runs
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, output int edge_no);
        int n;
        exp_t e;
        n = 0;
        edge_no = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = va;
        b = vb;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 2000);
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, expected accept for a=%0d b=%0d", va, vb);
            in_valid = 1'b0;
        end else begin
            edge_no = cyc + 1;
            e.prod = {{W{1'b0}}, va} * {{W{1'b0}}, vb};
            e.acc_edge = edge_no;
            q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e1;
        int e2;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {20'd0, product}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Max operands, result must persist into IDLE
        send(6'd63, 6'd63, e1);
        drain();
        repeat (2) @(negedge clk);
        check("idle_hold_product", {20'd0, product}, 32'h0000_0F81);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Zero operands still take the full CALC
        send(6'd0, 6'd45, e1);
        send(6'd45, 6'd0, e1);
        send(6'd1, 6'd1, e1);
        send(6'd33, 6'd2, e1);
        drain();

        // Downstream stall for 20 cycles
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(6'd7, 6'd9, e1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_product", {20'd0, product}, 32'd63);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_hold", {31'd0, in_ready}, 32'd1);
        check("valid_after_hold", {31'd0, out_valid}, 32'd0);

        // Operands offered during CALC must be ignored until IDLE
        send(6'd5, 6'd7, e1);
        send(6'd9, 6'd9, e2);
        check("issue_interval", e2 - e1, W + 2);
        drain();

        // Asynchronous reset in the third CALC cycle
        send(6'd11, 6'd13, e1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_product", {20'd0, product}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_stale_valid", {31'd0, out_valid}, 32'd0);
        end
        send(6'd2, 6'd3, e1);
        drain();
        check("post_reset_product", {20'd0, product}, 32'd6);

        // Exhaustive sweep with random stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                send(W'(i), W'(j), e1);
            end
        end
        drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
